// File: rtl/sonar_if.sv
// sonar_if: control, echo and result signals between the sonar scheduler and its host
// Ports (slave = scheduler side):
//   run, enable_mask, echo          -> into the scheduler
//   trig, range_data, range_valid,
//   timeout_flag, done, cur_idx,
//   busy                            <- out of the scheduler
interface sonar_if #(parameter int N_SONAR = 6);
    logic run;
    logic [N_SONAR-1:0] enable_mask;
    logic [N_SONAR-1:0] echo;
    logic [N_SONAR-1:0] trig;
    logic [20*N_SONAR-1:0] range_data;
    logic [N_SONAR-1:0] range_valid;
    logic [N_SONAR-1:0] timeout_flag;
    logic done;
    logic [2:0] cur_idx;
    logic busy;
    modport master (
        output run, enable_mask, echo,
        input trig, range_data, range_valid, timeout_flag, done, cur_idx, busy
    );
    modport slave (
        input run, enable_mask, echo,
        output trig, range_data, range_valid, timeout_flag, done, cur_idx, busy
    );
endinterface

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger/echo timing for N_SONAR ultrasonic rangers
// Ports:
//   clk    system clock
//   reset  synchronous, active-low
//   s      sonar_if.slave: run/enable_mask/echo in; trig, ranges, flags, done, cur_idx, busy out
module sonar_scheduler #(
    parameter int N_SONAR        = 6,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GUARD_CYCLES   = 250000
) (
    input  logic   clk,
    input  logic   reset,
    sonar_if.slave s
);
    typedef enum logic [2:0] {IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;
    localparam logic [19:0] TRIG_LAST  = 20'(TRIG_CYCLES - 1);
    localparam logic [19:0] TMO        = 20'(TIMEOUT_CYCLES);
    localparam logic [19:0] GUARD_LAST = 20'(GUARD_CYCLES - 1);
    state_t state_q, state_d;
    logic [2:0] ptr_q, ptr_d, cur_q, cur_d, nxt;
    logic [19:0] cnt_q, cnt_d, cnt_inc;
    logic [N_SONAR-1:0] sync1_q, sync2_q;
    logic [N_SONAR-1:0] valid_q, valid_d, tflag_q, tflag_d;
    logic [N_SONAR-1:0][19:0] range_q, range_d;
    logic done_q, done_d, echo_cur, wr, wr_tmo;
    assign echo_cur = sync2_q[cur_q];
    // counter stops at TMO, which is below 2^20, so the increment never wraps
    assign cnt_inc = cnt_q + 20'd1;
    // walk from the farthest candidate to the nearest so the nearest enabled index wins
    always_comb begin
        nxt = ptr_q;
        for (int k = N_SONAR; k >= 1; k--)
            if (s.enable_mask[(int'(ptr_q) + k) % N_SONAR]) nxt = 3'((int'(ptr_q) + k) % N_SONAR);
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        wr      = 1'b0;
        wr_tmo  = 1'b0;
        case (state_q)
            IDLE: if (s.run && |s.enable_mask) state_d = SELECT;
            SELECT: begin
                if (!s.run || ~|s.enable_mask) state_d = IDLE;
                else begin
                    ptr_d   = nxt;
                    cur_d   = nxt;
                    cnt_d   = '0;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                cnt_d   = (cnt_q == TRIG_LAST) ? '0 : cnt_inc;
                state_d = (cnt_q == TRIG_LAST) ? WAIT_RISE : TRIG;
            end
            WAIT_RISE: begin
                // the rising cycle is itself the first high cycle of the pulse
                cnt_d   = echo_cur ? 20'd1 : cnt_inc;
                state_d = echo_cur ? MEASURE : WAIT_RISE;
                wr      = !echo_cur && cnt_inc == TMO;
                wr_tmo  = wr;
            end
            MEASURE: begin
                cnt_d  = echo_cur ? cnt_inc : cnt_q;
                wr_tmo = echo_cur && cnt_inc == TMO;
                wr     = !echo_cur || wr_tmo;
            end
            GUARD: begin
                cnt_d   = (cnt_q == GUARD_LAST) ? '0 : cnt_inc;
                state_d = (cnt_q == GUARD_LAST) ? SELECT : GUARD;
            end
            default: state_d = IDLE;
        endcase
        if (wr) begin
            state_d = GUARD;
            cnt_d   = '0;
        end
        range_d = range_q;
        valid_d = valid_q;
        tflag_d = tflag_q;
        if (wr) begin
            range_d[cur_q] = wr_tmo ? 20'hFFFFF : cnt_q;
            valid_d[cur_q] = 1'b1;
            tflag_d[cur_q] = wr_tmo;
        end
        done_d = wr;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 3'(N_SONAR - 1);
            cur_q   <= '0;
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            range_q <= '0;
            valid_q <= '0;
            tflag_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            sync1_q <= s.echo;
            sync2_q <= sync1_q;
            range_q <= range_d;
            valid_q <= valid_d;
            tflag_q <= tflag_d;
            done_q  <= done_d;
        end
    end
    assign s.trig         = (state_q == TRIG) ? (N_SONAR'(1) << cur_q) : '0;
    assign s.range_data   = range_q;
    assign s.range_valid  = valid_q;
    assign s.timeout_flag = tflag_q;
    assign s.done         = done_q;
    assign s.cur_idx      = cur_q;
    assign s.busy         = state_q != IDLE;
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: randomized scoreboard bench for sonar_scheduler
module tb_sonar_scheduler;
    localparam int N = 6, TRIG = 4, TMO = 100, GUARD = 10;
    logic clk = 1'b0;
    logic reset = 1'b0;
    sonar_if #(.N_SONAR(N)) bus ();
    sonar_scheduler #(.N_SONAR(N), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GUARD)) dut (
        .clk(clk),
        .reset(reset),
        .s(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        int         idx;
        logic [19:0] rng;
        logic        tf;
    } exp_t;
    exp_t sb[$];
    logic [19:0] m_range[N];
    logic [N-1:0] m_valid, m_tflag;
    logic [20*N-1:0] flat;
    int m_ptr = N - 1;
    int vectors = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // next enabled sonar strictly after p, wrapping; p itself if it is the only one
    function automatic int model_next(input logic [N-1:0] m, input int p);
        for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return p;
    endfunction

    // monitor: pops the scoreboard on every done pulse and tracks published state
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) m_range[i] = '0;
            m_valid = '0;
            m_tflag = '0;
            sb.delete();
        end else begin
            if (bus.done) begin
                if (sb.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_idx", bus.cur_idx, e.idx);
                    check("done_range", bus.range_data[20*e.idx +: 20], e.rng);
                    check("done_tflag", bus.timeout_flag[e.idx], e.tf);
                    m_range[e.idx] = e.rng;
                    m_valid[e.idx] = 1'b1;
                    m_tflag[e.idx] = e.tf;
                end
            end
            for (int i = 0; i < N; i++) flat[20*i +: 20] = m_range[i];
            check("range_data_all", bus.range_data, flat);
            check("range_valid", bus.range_valid, m_valid);
            check("timeout_flag", bus.timeout_flag, m_tflag);
            check("trig_onehot", $countones(bus.trig) <= 1, 1);
        end
    end

    task automatic noise(input logic [N-1:0] other);
        bus.echo = N'($urandom) & other;
        @(negedge clk);
    endtask

    task automatic wait_trig(output int idx);
        int n = 0;
        idx = -1;
        while (bus.trig == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("trig_seen", bus.trig != 0, 1);
        for (int i = 0; i < N; i++) if (bus.trig[i]) idx = i;
    endtask

    // w = echo width in cycles (0 = no echo), d = delay after trigger
    task automatic do_ping(input int w, input int d, input logic [N-1:0] mid_mask, input bit drop_run);
        int idx, exp_idx, len, n;
        logic [N-1:0] other;
        exp_t e;
        exp_idx = model_next(bus.enable_mask, m_ptr);
        wait_trig(idx);
        if (idx < 0) return;
        check("trig_idx", idx, exp_idx);
        check("busy_ping", bus.busy, 1);
        m_ptr = exp_idx;
        e.idx = exp_idx;
        e.tf  = (w == 0 || w >= TMO);
        e.rng = e.tf ? 20'hFFFFF : 20'(w);
        sb.push_back(e);
        other = ~(N'(1) << idx);
        len = 0;
        while (bus.trig[idx] && len < 50) begin
            len++;
            noise(other);
        end
        check("trig_len", len, TRIG);
        if (drop_run) bus.run = 1'b0;
        repeat (d) noise(other);
        for (int i = 0; i < w && !bus.done; i++) begin
            bus.echo = (N'($urandom) & other) | (N'(1) << idx);
            if (i == w / 2 && mid_mask != 0) bus.enable_mask = mid_mask;
            @(negedge clk);
        end
        bus.echo = '0;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", sb.size(), 0);
    endtask

    task automatic check_reset();
        check("rst_trig", bus.trig, 0);
        check("rst_range", bus.range_data, 0);
        check("rst_valid", bus.range_valid, 0);
        check("rst_tflag", bus.timeout_flag, 0);
        check("rst_done", bus.done, 0);
        check("rst_cur", bus.cur_idx, 0);
        check("rst_busy", bus.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int idx, any, w;
        bus.run = 1'b0;
        bus.enable_mask = '0;
        bus.echo = '0;
        repeat (3) @(negedge clk);
        check_reset();
        bus.enable_mask = 6'b000101;
        bus.run = 1'b1;
        reset = 1'b1;
        do_ping(37, 0, '0, 0);
        do_ping(12, 3, '0, 0);
        do_ping(1, 5, '0, 0);
        bus.enable_mask = 6'b001000;
        do_ping(0, 0, '0, 0);
        do_ping(0, 0, '0, 0);
        bus.enable_mask = 6'b000010;
        do_ping(150, 2, '0, 0);
        do_ping(20, 4, '0, 0);
        bus.enable_mask = 6'b000011;
        do_ping(20, 2, 6'b000100, 0);
        do_ping(8, 1, '0, 0);
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) bus.enable_mask = N'($urandom_range(1, (1 << N) - 1));
            case ($urandom_range(0, 7))
                0: w = 0;
                1: w = 1;
                2: w = 99;
                3: w = 100;
                4: w = 150;
                default: w = $urandom_range(1, 120);
            endcase
            do_ping(w, $urandom_range(0, 10), '0, 0);
        end
        do_ping(30, 3, '0, 1);
        repeat (GUARD + 5) @(negedge clk);
        check("idle_busy", bus.busy, 0);
        any = 0;
        repeat (30) begin
            @(negedge clk);
            any |= int'(bus.trig != 0);
        end
        check("idle_trig", any, 0);
        bus.enable_mask = 6'b010000;
        bus.run = 1'b1;
        wait_trig(idx);
        check("rst_test_idx", idx, model_next(6'b010000, m_ptr));
        reset = 1'b0;
        @(negedge clk);
        check_reset();
        m_ptr = N - 1;
        repeat (2) @(negedge clk);
        bus.enable_mask = 6'b000101;
        reset = 1'b1;
        do_ping(15, 1, '0, 0);
        do_ping(25, 2, '0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
